// File: rtl/fixed_pkg.sv
// Shared fixed-point definitions: default word format, divider states and
// the saturation limits for the default width.
package fixed_pkg;

    localparam int FX_N = 16;
    localparam int FX_Q = 8;

    localparam logic [FX_N-1:0] FX_MAX = {1'b0, {(FX_N-1){1'b1}}};
    localparam logic [FX_N-1:0] FX_MIN = {1'b1, {(FX_N-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

endpackage

// File: rtl/fixed_divider_if.sv
// Request/result bundle for the fixed-point divider.
interface fixed_divider_if
    import fixed_pkg::*;
#(
    parameter int N = FX_N
) ();

    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [N-1:0] C;
    logic         busy;
    logic         done;
    logic         ovf;
    logic         dz;

    modport master (
        output start, A, B,
        input  C, busy, done, ovf, dz
    );

    modport slave (
        input  start, A, B,
        output C, busy, done, ovf, dz
    );

endinterface

// File: rtl/udiv_core.sv
// Unsigned restoring divider: one quotient bit per clock, MSB first, with the
// quotient shifted into the dividend register as the dividend bits drain out.
module udiv_core
    import fixed_pkg::*;
#(
    parameter int N = FX_N,
    parameter int Q = FX_Q
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic           run,
    input  logic [N+Q-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic [N+Q-1:0] quotient_next,
    output logic           last
);

    localparam int W     = N + Q;
    localparam int CNT_W = $clog2(W + 1);

    logic [N:0]       rem_q;
    logic [N:0]       rem_next;
    logic [W-1:0]     dq_q;
    logic [N-1:0]     div_q;
    logic [CNT_W-1:0] cnt_q;
    logic [N+1:0]     rem_shift;
    logic [N+1:0]     diff;
    logic             fits;

    // The borrow out of the trial subtraction decides the quotient bit.
    always_comb begin
        rem_shift     = {rem_q, dq_q[W-1]};
        diff          = rem_shift - {2'b00, div_q};
        fits          = ~diff[N+1];
        rem_next      = fits ? diff[N:0] : rem_shift[N:0];
        quotient_next = {dq_q[W-2:0], fits};
    end

    assign last = (cnt_q == CNT_W'(W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            dq_q  <= '0;
            div_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            dq_q  <= dividend;
            div_q <= divisor;
            cnt_q <= '0;
        end else if (run) begin
            rem_q <= rem_next;
            dq_q  <= quotient_next;
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/fixed_divider.sv
// Signed fixed-point divider: sign/magnitude conversion, divide-by-zero and
// saturation around an unsigned iterative core.
module fixed_divider
    import fixed_pkg::*;
#(
    parameter int N = FX_N,
    parameter int Q = FX_Q
) (
    input  logic           clk,
    input  logic           rst_n,
    fixed_divider_if.slave bus
);

    localparam int W = N + Q;

    localparam logic [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};
    localparam logic [W-1:0] POS_LIM = W'(SAT_MAX);
    localparam logic [W-1:0] NEG_LIM = W'(SAT_MIN);

    div_state_t   state_q;
    div_state_t   state_d;
    logic         load;
    logic         run;
    logic         last;
    logic         accept;
    logic         sign_q;
    logic [N-1:0] a_mag;
    logic [N-1:0] b_mag;
    logic [W-1:0] q_mag;
    logic [N-1:0] sat_c;
    logic         sat_ovf;
    logic [N-1:0] c_q;
    logic         ovf_q;
    logic         dz_q;

    // Negating the most negative value wraps to itself, which is the
    // correct unsigned magnitude 2^(N-1).
    assign a_mag  = bus.A[N-1] ? -bus.A : bus.A;
    assign b_mag  = bus.B[N-1] ? -bus.B : bus.B;
    assign accept = (state_q == IDLE) && bus.start;

    udiv_core #(
        .N(N),
        .Q(Q)
    ) u_core (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (load),
        .run           (run),
        .dividend      ({a_mag, {Q{1'b0}}}),
        .divisor       (b_mag),
        .quotient_next (q_mag),
        .last          (last)
    );

    // A negative result may reach one step further than a positive one.
    always_comb begin
        sat_ovf = 1'b0;
        sat_c   = q_mag[N-1:0];
        if (sign_q) begin
            if (q_mag > NEG_LIM) begin
                sat_ovf = 1'b1;
                sat_c   = SAT_MIN;
            end else begin
                sat_c   = -q_mag[N-1:0];
            end
        end else if (q_mag > POS_LIM) begin
            sat_ovf = 1'b1;
            sat_c   = SAT_MAX;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        run     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.B == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                        load    = 1'b1;
                    end
                end
            end
            CALC: begin
                run = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Results change only on the edge that enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q <= 1'b0;
            c_q    <= '0;
            ovf_q  <= 1'b0;
            dz_q   <= 1'b0;
        end else if (accept) begin
            sign_q <= bus.A[N-1] ^ bus.B[N-1];
            if (bus.B == '0) begin
                c_q   <= bus.A[N-1] ? SAT_MIN : SAT_MAX;
                ovf_q <= 1'b0;
                dz_q  <= 1'b1;
            end
        end else if ((state_q == CALC) && last) begin
            c_q   <= sat_c;
            ovf_q <= sat_ovf;
            dz_q  <= 1'b0;
        end
    end

    assign bus.C    = c_q;
    assign bus.ovf  = ovf_q;
    assign bus.dz   = dz_q;
    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);

endmodule
